// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, flag bit positions,
// instruction field layout and FSM state encoding.
package alu_seq_pkg;

  localparam int SEQ_DATA_W = 16;
  localparam int SEQ_NREG   = 16;
  localparam int RA_W       = 4;
  localparam int INS_W      = 16;
  localparam int OP_W       = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_ORR = 3'd3;
  localparam logic [OP_W-1:0] OP_NOT = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR = 3'd5;
  localparam logic [OP_W-1:0] OP_LSR = 3'd6;
  localparam logic [OP_W-1:0] OP_LSL = 3'd7;

  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_N = 1;
  localparam int FLG_P = 0;

  // Instruction layout: [15] illegal marker, [14:12] op, [11:8] rd, [7:4] rs, [3:0] rt
  localparam int INS_ILL_BIT = 15;
  localparam int INS_OP_LSB  = 12;
  localparam int INS_RD_LSB  = 8;
  localparam int INS_RS_LSB  = 4;
  localparam int INS_RT_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file: NREG x DATA_W, three combinational read ports, one write port.
// r0 is hardwired to zero on every read port; writes to r0 are dropped.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int NREG   = SEQ_NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [RA_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RA_W-1:0]   raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [RA_W-1:0]   raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [RA_W-1:0]   raddr_c_i,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic [DATA_W-1:0] mem_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];
  assign rdata_c_o = (raddr_c_i == '0) ? '0 : mem_q[raddr_c_i];

endmodule

// File: rtl/alu_seq.sv
// Sequencer driving a combinational ALU: IDLE -> READ -> EXEC -> WB, owns registers and flags.
// Define ALU_SEQ_B2B_EN to accept in WB (1 instr / 3 cycles) with result forwarding.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = SEQ_DATA_W,
  parameter int NREG   = SEQ_NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INS_W-1:0]  in_instr,
  input  logic              ld_en,
  input  logic [RA_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] alu_rs,
  output logic [DATA_W-1:0] alu_rt,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_rd,
  input  logic              alu_fz,
  input  logic              alu_fc,
  input  logic              alu_fn,
  input  logic              alu_fp,
  output logic [3:0]        flags,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [INS_W-1:0]  instr_q, instr_d;
  logic [DATA_W-1:0] alu_rs_q, alu_rs_d, alu_rt_q, alu_rt_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [3:0]        fhold_q, fhold_d, flags_q, flags_d;
  logic              done_q, done_d, err_q, err_d;

  logic [RA_W-1:0]   rs_a, rt_a, rd_a;
  logic [DATA_W-1:0] rf_rs, rf_rt, op_a, op_b;
  logic              we;
  logic [RA_W-1:0]   waddr;
  logic [DATA_W-1:0] wdata;

  assign rs_a = instr_q[INS_RS_LSB +: RA_W];
  assign rt_a = instr_q[INS_RT_LSB +: RA_W];
  assign rd_a = instr_q[INS_RD_LSB +: RA_W];

  alu_seq_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (we),
    .waddr_i   (waddr),
    .wdata_i   (wdata),
    .raddr_a_i (rs_a),
    .rdata_a_o (rf_rs),
    .raddr_b_i (rt_a),
    .rdata_b_o (rf_rt),
    .raddr_c_i (dbg_addr),
    .rdata_c_o (dbg_data)
  );

`ifdef ALU_SEQ_B2B_EN
  logic              fwd_vld_q, fwd_vld_d;
  logic [RA_W-1:0]   fwd_addr_q, fwd_addr_d;
  logic [DATA_W-1:0] fwd_dat_q, fwd_dat_d;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
  // Operands of an instruction accepted in WB see the result written in that WB.
  assign op_a = (fwd_vld_q && (fwd_addr_q == rs_a)) ? fwd_dat_q : rf_rs;
  assign op_b = (fwd_vld_q && (fwd_addr_q == rt_a)) ? fwd_dat_q : rf_rt;

  always_comb begin
    fwd_vld_d  = 1'b0;
    fwd_addr_d = fwd_addr_q;
    fwd_dat_d  = fwd_dat_q;
    if ((state_q == ST_WB) && in_valid) begin
      fwd_vld_d  = (rd_a != '0);
      fwd_addr_d = rd_a;
      fwd_dat_d  = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_vld_q  <= 1'b0;
      fwd_addr_q <= '0;
      fwd_dat_q  <= '0;
    end else begin
      fwd_vld_q  <= fwd_vld_d;
      fwd_addr_q <= fwd_addr_d;
      fwd_dat_q  <= fwd_dat_d;
    end
  end
`else
  assign in_ready = (state_q == ST_IDLE);
  assign op_a     = rf_rs;
  assign op_b     = rf_rt;
`endif

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    alu_rs_d = alu_rs_q;
    alu_rt_d = alu_rt_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    fhold_d  = fhold_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    we       = 1'b0;
    waddr    = rd_a;
    wdata    = res_q;
    case (state_q)
      ST_IDLE: begin
        // An accept wins over a simultaneous loader write.
        if (in_valid) begin
          instr_d = in_instr;
          state_d = ST_READ;
        end else if (ld_en) begin
          we    = 1'b1;
          waddr = ld_addr;
          wdata = ld_data;
        end
      end
      ST_READ: begin
        if (instr_q[INS_ILL_BIT]) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          alu_rs_d = op_a;
          alu_rt_d = op_b;
          alu_op_d = instr_q[INS_OP_LSB +: OP_W];
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d          = alu_rd;
        fhold_d[FLG_Z] = alu_fz;
        fhold_d[FLG_C] = alu_fc;
        fhold_d[FLG_N] = alu_fn;
        fhold_d[FLG_P] = alu_fp;
        done_d         = 1'b1;
        state_d        = ST_WB;
      end
      ST_WB: begin
        we      = 1'b1;
        flags_d = fhold_q;
        state_d = ST_IDLE;
`ifdef ALU_SEQ_B2B_EN
        if (in_valid) begin
          instr_d = in_instr;
          state_d = ST_READ;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      alu_rs_q <= '0;
      alu_rt_q <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      fhold_q  <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      alu_rs_q <= alu_rs_d;
      alu_rt_q <= alu_rt_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      fhold_q  <= fhold_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign alu_rs = alu_rs_q;
  assign alu_rt = alu_rt_q;
  assign alu_op = alu_op_q;
  assign flags  = flags_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU; define ALU_SEQ_B2B_EN to add the back-to-back case.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [15:0] in_instr;
  logic        ld_en;
  logic [3:0]  ld_addr, dbg_addr;
  logic [15:0] ld_data, dbg_data;
  logic [15:0] alu_rs, alu_rt, alu_rd;
  logic [2:0]  alu_op;
  logic        alu_fz, alu_fc, alu_fn, alu_fp;
  logic [3:0]  flags;
  logic        done, err;

  int checks = 0;
  int errors = 0;
  int lat_done, lat_err;
  logic [2:0] op_at_done;

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_op(alu_op), .alu_rd(alu_rd),
    .alu_fz(alu_fz), .alu_fc(alu_fc), .alu_fn(alu_fn), .alu_fp(alu_fp),
    .flags(flags), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference ALU: C is carry for ADD, borrow for SUB, 0 otherwise.
  logic [16:0] sum;
  logic [15:0] res;
  logic        cy;
  always_comb begin
    sum = '0;
    res = '0;
    cy  = 1'b0;
    case (alu_op)
      OP_ADD: begin sum = {1'b0, alu_rs} + {1'b0, alu_rt}; res = sum[15:0]; cy = sum[16]; end
      OP_SUB: begin res = alu_rs - alu_rt; cy = (alu_rs < alu_rt); end
      OP_AND: res = alu_rs & alu_rt;
      OP_ORR: res = alu_rs | alu_rt;
      OP_NOT: res = ~alu_rs;
      OP_XOR: res = alu_rs ^ alu_rt;
      OP_LSR: res = alu_rs >> alu_rt[3:0];
      OP_LSL: res = alu_rs << alu_rt[3:0];
      default: res = '0;
    endcase
  end
  assign alu_rd = res;
  assign alu_fz = (res == 16'h0000);
  assign alu_fc = cy;
  assign alu_fn = res[15];
  assign alu_fp = (res != 16'h0000) && !res[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reg(input string nm, input logic [3:0] a, input logic [15:0] e);
    dbg_addr = a;
    #1;
    chk(nm, {16'h0, dbg_data}, {16'h0, e});
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Issues one instruction; cycle 0 is the accept cycle, latencies count cycles after it.
  task automatic issue(input logic [15:0] ins, input logic do_ld, input logic [3:0] la,
                       input logic [15:0] ldd);
    lat_done = -1; lat_err = -1; op_at_done = 3'h0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = ins;
    if (do_ld) begin ld_en = 1'b1; ld_addr = la; ld_data = ldd; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      if (n == 4) ld_en = 1'b0;
      if (done && lat_done < 0) begin lat_done = n; op_at_done = alu_op; end
      if (err && lat_err < 0) lat_err = n;
      if (n < 6) begin @(posedge clk); #1; end
    end
  endtask

  typedef struct packed {
    logic [15:0] instr;
    logic [3:0]  addr;
    logic [15:0] val;
    logic [3:0]  flg;
  } vec_t;

  vec_t vt [11];
  int   seen;

  initial begin
    vt[0]  = '{16'h0312, 4'd3,  16'h0003, 4'b0001};  // ADD 1+2
    vt[1]  = '{16'h1411, 4'd4,  16'h0000, 4'b1000};  // SUB to zero
    vt[2]  = '{16'h0012, 4'd0,  16'h0000, 4'b0001};  // write to r0 dropped, flags update
    vt[3]  = '{16'h1512, 4'd5,  16'hFFFF, 4'b0110};  // SUB with borrow
    vt[4]  = '{16'h6653, 4'd6,  16'h1FFF, 4'b0001};  // LSR by 3
    vt[5]  = '{16'h4760, 4'd7,  16'hE000, 4'b0010};  // NOT
    vt[6]  = '{16'h5876, 4'd8,  16'hFFFF, 4'b0010};  // XOR
    vt[7]  = '{16'h3903, 4'd9,  16'h0003, 4'b0001};  // ORR with r0 operand
    vt[8]  = '{16'h7A33, 4'd10, 16'h0018, 4'b0001};  // LSL by 3
    vt[9]  = '{16'h0B88, 4'd11, 16'hFFFE, 4'b0110};  // ADD with carry
    vt[10] = '{16'h0C51, 4'd12, 16'h0000, 4'b1100};  // ADD wrap to zero

    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    #22;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_alu_op", {29'h0, alu_op}, 32'h0);
    for (int a = 0; a < 16; a++) chk_reg($sformatf("rst_r%0d", a), 4'(a), 16'h0000);

    load(4'd1, 16'h0001);
    load(4'd2, 16'h0002);
    load(4'd0, 16'hBEEF);
    chk_reg("ld_r1", 4'd1, 16'h0001);
    chk_reg("ld_r0_ignored", 4'd0, 16'h0000);

    for (int i = 0; i < 11; i++) begin
      issue(vt[i].instr, 1'b0, 4'd0, 16'h0);
      chk($sformatf("v%0d_done_lat", i), lat_done, 32'd3);
      chk($sformatf("v%0d_no_err", i), lat_err, 32'hFFFF_FFFF);
      chk($sformatf("v%0d_alu_op", i), {29'h0, op_at_done}, {29'h0, vt[i].instr[14:12]});
      chk_reg($sformatf("v%0d_result", i), vt[i].addr, vt[i].val);
      chk($sformatf("v%0d_flags", i), {28'h0, flags}, {28'h0, vt[i].flg});
    end

    issue(16'h8312, 1'b0, 4'd0, 16'h0);
    chk("ill_err_lat", lat_err, 32'd2);
    chk("ill_no_done", lat_done, 32'hFFFF_FFFF);
    chk_reg("ill_r3", 4'd3, 16'h0003);
    chk("ill_flags", {28'h0, flags}, 32'hC);
    chk("ill_in_ready", {31'h0, in_ready}, 32'h1);

    // Loader strobe held from the accept cycle through WB must never land.
    issue(16'h0D11, 1'b1, 4'd14, 16'h5555);
    chk("col_done_lat", lat_done, 32'd3);
    chk_reg("col_r13", 4'd13, 16'h0002);
    chk_reg("col_r14", 4'd14, 16'h0000);
    chk("col_flags", {28'h0, flags}, 32'h1);

    load(4'd1, 16'h0006);
    load(4'd2, 16'h0005);
    issue(16'h2512, 1'b0, 4'd0, 16'h0);
    chk("and_done_lat", lat_done, 32'd3);
    chk_reg("and_r5", 4'd5, 16'h0004);

    @(negedge clk);
    in_valid = 1'b1; in_instr = 16'h7311;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mrst_flags", {28'h0, flags}, 32'h0);
    chk("mrst_alu_op", {29'h0, alu_op}, 32'h0);
    chk_reg("mrst_r5", 4'd5, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    chk("mrst_no_done", seen, 32'd0);

`ifdef ALU_SEQ_B2B_EN
    load(4'd1, 16'h0001);
    load(4'd2, 16'h0002);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 16'h0312;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_done1", {31'h0, done}, 32'h1);
    chk("b2b_ready_wb", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1; in_instr = 16'h7633;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat_done = -1;
    for (int n = 1; n <= 6; n++) begin
      if (done && lat_done < 0) lat_done = n;
      if (n < 6) begin @(posedge clk); #1; end
    end
    chk("b2b_done_spacing", lat_done, 32'd3);
    chk_reg("b2b_r3", 4'd3, 16'h0003);
    chk_reg("b2b_r6", 4'd6, 16'h0018);
    chk("b2b_flags", {28'h0, flags}, 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
